tlul_host_arb: RTL and testbench
================================

// Module: tlul_host_arb
// PURPOSE
//  Shares one TL-UL device port (typically a tlul_adapter_reg-fronted register block) between NumHosts TL-UL hosts.
//  Round-robin arbitration on the A channel; exactly one transaction in flight; D response routed back to the winner.
//  Sits between host-side crossbar ports and a single-outstanding register device.
// PARAMETERS
//  NumHosts  2  number of host ports, 2..8
//  HostIdxW  $clog2(NumHosts)  localparam, grant index width
// PORTS
//  clk_i      in   1                  clock, single domain
//  rst_ni     in   1                  reset, asynchronous, active-low
//  tl_h_i     in   NumHosts x tl_h2d_t  host requests
//  tl_h_o     out  NumHosts x tl_d2h_t  host responses
//  tl_d_o     out  tl_h2d_t           request to shared device
//  tl_d_i     in   tl_d2h_t           response from shared device
//  gnt_o      out  NumHosts           one-hot owner of the device port, 0 when idle
//  idle_o     out  1                  1 when no transaction in flight (state IDLE)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, gnt_q=0; tl_d_o.a_valid=0, tl_d_o.d_ready=0, all tl_h_o a_ready=0/d_valid=0, gnt_o=0, idle_o=1.
//  FSM states IDLE, ADDR, DATA:
//   IDLE: pick = first host with a_valid searching from rr_ptr upward, wrapping. If any a_valid:
//     forward pick's A fields + a_valid to tl_d_o same cycle (0-cycle latency); tl_h_o[pick].a_ready = tl_d_i.a_ready.
//     a_ack (a_valid & a_ready) -> DATA; no a_ack -> ADDR. Either way gnt_q<=pick (locked).
//   ADDR: forward locked host's A channel unchanged; other hosts ignored; a_ack -> DATA.
//     Host dropping a_valid (protocol violation): a_valid forwarded as 0, grant stays locked.
//   DATA: tl_d_o.a_valid=0; tl_d_o.d_ready = tl_h_i[gnt_q].d_ready; tl_h_o[gnt_q].d_valid = tl_d_i.d_valid.
//     d_ack -> IDLE, rr_ptr <= (gnt_q==NumHosts-1) ? 0 : gnt_q+1.
//  D fields (opcode,param,size,source,sink,data,user,error) passed unmodified to all hosts; only d_valid gated per host.
//  a_source passes through unchanged (single outstanding, no ID remap).
//  Non-granted hosts: a_ready=0, d_valid=0 in every state.
//  a_ready to winner is never registered; back-to-back: after d_ack in cycle N, new request accepted earliest N+1.
//  Device d_valid while IDLE/ADDR: ignored, d_ready=0 (device-side protocol violation).
//  Fairness: host waits at most NumHosts-1 transactions after asserting a_valid.
//  Reset mid-transaction: immediate return to reset values; in-flight response dropped.
//  gnt_o = 0 in IDLE, onehot(gnt_q) in ADDR/DATA; idle_o = (state==IDLE).
// STRUCTURE
//  tlul_pkg: tl_h2d_t, tl_d2h_t, opcode enums (existing); add TlHostArbMaxHosts=8 constant.
//  State enum local to the module (3 states, binary encoded).
//  One sub-module: tlul_rr_pick (combinational: req vector + ptr -> valid + index), reusable by sockets.
//  Expected size ~180 lines incl. picker.
// TESTING
//  1 NumHosts=2, host0 Get addr 0x10 only, device a_ready=1 -> a_ack cycle 0, gnt_o=01, host0 gets d_valid, host1 d_valid=0.
//  2 both hosts Get every cycle for 6 txns -> grants alternate 0,1,0,1,0,1; no host starved; a_source echoed per host.
//  3 device a_ready=0 for 3 cycles, host1 raises a_valid meanwhile -> host0 stays granted (ADDR), host1 a_ready=0.
//  4 host0 d_ready=0 for 4 cycles in DATA -> tl_d_o.d_ready=0, D held, no new grant until d_ack; then rr_ptr=1.
//  5 rst_ni low during DATA -> all outputs at reset values asynchronously; after release first request from host1 served.
//  6 PutFullData data 0xDEADBEEF mask 0xF from host1, device d_error=1 -> host1 sees d_error=1, opcode AccessAck, same source.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL shared types: channel structs, opcode enums and bus widths.
package tlul_pkg;

    localparam int unsigned TlHostArbMaxHosts = 8;

    localparam int unsigned TlAW    = 32;
    localparam int unsigned TlDW    = 32;
    localparam int unsigned TlDBW   = TlDW / 8;
    localparam int unsigned TlSzW   = 2;
    localparam int unsigned TlAIW   = 8;
    localparam int unsigned TlDIW   = 1;
    localparam int unsigned TlUserW = 16;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                 a_valid;
        tl_a_op_e             a_opcode;
        logic [2:0]           a_param;
        logic [TlSzW-1:0]     a_size;
        logic [TlAIW-1:0]     a_source;
        logic [TlAW-1:0]      a_address;
        logic [TlDBW-1:0]     a_mask;
        logic [TlDW-1:0]      a_data;
        logic [TlUserW-1:0]   a_user;
        logic                 d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                 d_valid;
        tl_d_op_e             d_opcode;
        logic [2:0]           d_param;
        logic [TlSzW-1:0]     d_size;
        logic [TlAIW-1:0]     d_source;
        logic [TlDIW-1:0]     d_sink;
        logic [TlDW-1:0]      d_data;
        logic [TlUserW-1:0]   d_user;
        logic                 d_error;
        logic                 a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module tlul_rr_pick #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic            valid,
    output logic [IdxW-1:0] idx
);

    int cand;

    // Scan N candidates starting at ptr, keep the first one that is requesting.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 0; i < int'(N); i++) begin
            cand = int'(ptr) + i;
            if (cand >= int'(N)) begin
                cand = cand - int'(N);
            end
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/tlul_host_arb.sv
// Shares one single-outstanding TL-UL device port between NumHosts hosts.
// Round-robin on the A channel, one transaction in flight, D routed to the winner.
module tlul_host_arb
    import tlul_pkg::*;
#(
    parameter  int unsigned NumHosts = 2,
    localparam int unsigned HostIdxW = $clog2(NumHosts)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  tl_h2d_t             tl_h_i [NumHosts],
    output tl_d2h_t             tl_h_o [NumHosts],
    output tl_h2d_t             tl_d_o,
    input  tl_d2h_t             tl_d_i,
    output logic [NumHosts-1:0] gnt_o,
    output logic                idle_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [HostIdxW-1:0] gnt_q, gnt_d;
    logic [HostIdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [NumHosts-1:0] a_valid_vec;
    logic                pick_valid;
    logic [HostIdxW-1:0] pick_idx;

    // Collect the host request lines for the picker.
    always_comb begin
        a_valid_vec = '0;
        for (int i = 0; i < int'(NumHosts); i++) begin
            a_valid_vec[i] = tl_h_i[i].a_valid;
        end
    end

    tlul_rr_pick #(
        .N    (NumHosts),
        .IdxW (HostIdxW)
    ) u_pick (
        .req   (a_valid_vec),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State, locked owner and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next state and channel steering; the reset gate keeps the forwarded A
    // channel quiet while reset is held even if hosts are requesting.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        tl_d_o   = '0;
        for (int i = 0; i < int'(NumHosts); i++) begin
            tl_h_o[i]         = tl_d_i;
            tl_h_o[i].d_valid = 1'b0;
            tl_h_o[i].a_ready = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (rst_ni && pick_valid) begin
                    tl_d_o                   = tl_h_i[pick_idx];
                    tl_d_o.d_ready           = 1'b0;
                    tl_h_o[pick_idx].a_ready = tl_d_i.a_ready;
                    gnt_d                    = pick_idx;
                    state_d                  = tl_d_i.a_ready ? StData : StAddr;
                end
            end
            StAddr: begin
                tl_d_o                = tl_h_i[gnt_q];
                tl_d_o.d_ready        = 1'b0;
                tl_h_o[gnt_q].a_ready = tl_d_i.a_ready;
                if (tl_h_i[gnt_q].a_valid && tl_d_i.a_ready) begin
                    state_d = StData;
                end
            end
            StData: begin
                tl_d_o.d_ready        = tl_h_i[gnt_q].d_ready;
                tl_h_o[gnt_q].d_valid = tl_d_i.d_valid;
                if (tl_d_i.d_valid && tl_h_i[gnt_q].d_ready) begin
                    state_d  = StIdle;
                    rr_ptr_d = (gnt_q == HostIdxW'(NumHosts - 1)) ? '0
                                                                  : gnt_q + HostIdxW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Grant and idle status derived from the registered state.
    always_comb begin
        gnt_o  = '0;
        idle_o = (state_q == StIdle);
        if (state_q != StIdle) begin
            gnt_o[gnt_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed bench for tlul_host_arb with two hosts, a simple device model and
// a response scoreboard checked by an independent monitor.
module tb_tlul_host_arb;
    import tlul_pkg::*;

    localparam int NumHosts = 2;

    typedef struct {
        int          host;
        logic [7:0]  src;
        logic [2:0]  op;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic                clk_i;
    logic                rst_ni;
    tl_h2d_t             tl_h_i [NumHosts];
    tl_d2h_t             tl_h_o [NumHosts];
    tl_h2d_t             tl_d_o;
    tl_d2h_t             tl_d_i;
    logic [NumHosts-1:0] gnt_o;
    logic                idle_o;

    tl_h2d_t             h_req [NumHosts];
    logic                h_dready [NumHosts];
    tl_d2h_t             dev_rsp;
    logic                dev_a_ready;
    logic                dev_err;

    tl_h2d_t             hq0 [$];
    tl_h2d_t             hq1 [$];
    exp_t                sb [$];

    int                  total;
    int                  bad;

    tlul_host_arb #(.NumHosts(NumHosts)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tl_h_i (tl_h_i),
        .tl_h_o (tl_h_o),
        .tl_d_o (tl_d_o),
        .tl_d_i (tl_d_i),
        .gnt_o  (gnt_o),
        .idle_o (idle_o)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Merge host request state and per-host d_ready into the DUT inputs.
    always_comb begin
        for (int h = 0; h < NumHosts; h++) begin
            tl_h_i[h]         = h_req[h];
            tl_h_i[h].d_ready = h_dready[h];
        end
    end

    // Merge the device response with the separately controlled a_ready.
    always_comb begin
        tl_d_i         = dev_rsp;
        tl_d_i.a_ready = dev_a_ready;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Queue one host request and, when a response is due, its expected D beat.
    task automatic applyStimulus(input int host, input tl_a_op_e op, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] mask,
                                 input logic [7:0] src, input bit expect_rsp,
                                 input tl_d_op_e exp_op, input logic exp_err,
                                 input logic [31:0] exp_data);
        tl_h2d_t r;
        exp_t    e;
        r           = '0;
        r.a_opcode  = op;
        r.a_size    = 2'd2;
        r.a_source  = src;
        r.a_address = addr;
        r.a_mask    = mask;
        r.a_data    = data;
        if (host == 0) hq0.push_back(r);
        else           hq1.push_back(r);
        if (expect_rsp) begin
            e.host = host;
            e.src  = src;
            e.op   = 3'(exp_op);
            e.err  = exp_err;
            e.data = exp_data;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Wait for all expected responses, bounded; a stuck run counts as a failure.
    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    // Host agents: hold a_valid until accepted, then present the next queued request.
    initial begin
        bit acked [NumHosts];
        for (int h = 0; h < NumHosts; h++) begin
            h_req[h] = '0;
            acked[h] = 1'b0;
        end
        forever begin
            @(negedge clk_i);
            for (int h = 0; h < NumHosts; h++) begin
                acked[h] = rst_ni && h_req[h].a_valid && tl_h_o[h].a_ready;
            end
            @(posedge clk_i);
            #2;
            for (int h = 0; h < NumHosts; h++) begin
                if (!rst_ni) begin
                    h_req[h] = '0;
                end else begin
                    if (acked[h]) h_req[h].a_valid = 1'b0;
                    if (!h_req[h].a_valid) begin
                        if (h == 0 && hq0.size() > 0) begin
                            h_req[h] = hq0.pop_front();
                            h_req[h].a_valid = 1'b1;
                        end else if (h == 1 && hq1.size() > 0) begin
                            h_req[h] = hq1.pop_front();
                            h_req[h].a_valid = 1'b1;
                        end
                    end
                end
            end
            if (!rst_ni) begin
                hq0.delete();
                hq1.delete();
            end
        end
    end

    // Device model: answers one cycle after acceptance, Get returns addr ^ A5A50000.
    initial begin
        bit      a_ack;
        bit      d_ack;
        tl_h2d_t cap;
        dev_rsp = '0;
        forever begin
            @(negedge clk_i);
            a_ack = tl_d_o.a_valid && tl_d_i.a_ready;
            d_ack = tl_d_i.d_valid && tl_d_o.d_ready;
            cap   = tl_d_o;
            @(posedge clk_i);
            #3;
            if (!rst_ni) begin
                dev_rsp = '0;
            end else begin
                if (d_ack) dev_rsp.d_valid = 1'b0;
                if (a_ack) begin
                    dev_rsp          = '0;
                    dev_rsp.d_valid  = 1'b1;
                    dev_rsp.d_source = cap.a_source;
                    dev_rsp.d_size   = cap.a_size;
                    dev_rsp.d_error  = dev_err;
                    if (cap.a_opcode == Get) begin
                        dev_rsp.d_opcode = AccessAckData;
                        dev_rsp.d_data   = cap.a_address ^ 32'hA5A5_0000;
                    end else begin
                        dev_rsp.d_opcode = AccessAck;
                        dev_rsp.d_data   = 32'h0;
                    end
                end
            end
        end
    end

    // Monitor: every host D handshake is matched against the scoreboard head.
    initial begin
        exp_t e;
        int   nvalid;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                nvalid = 0;
                for (int h = 0; h < NumHosts; h++) begin
                    if (tl_h_o[h].d_valid) nvalid++;
                end
                if (nvalid > 1) checkOutput("dvalid_onehot", 32'(nvalid), 32'd1);
                for (int h = 0; h < NumHosts; h++) begin
                    if (tl_h_o[h].d_valid && h_dready[h]) begin
                        if (sb.size() == 0) begin
                            checkOutput("unexpected_rsp_host", 32'(h), 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            checkOutput("rsp_host",   32'(h),                     32'(e.host));
                            checkOutput("rsp_source", 32'(tl_h_o[h].d_source),    32'(e.src));
                            checkOutput("rsp_opcode", 32'(tl_h_o[h].d_opcode),    32'(e.op));
                            checkOutput("rsp_error",  32'(tl_h_o[h].d_error),     32'(e.err));
                            checkOutput("rsp_data",   tl_h_o[h].d_data,           e.data);
                        end
                    end
                end
            end
        end
    end

    // Directed test sequence.
    initial begin
        total       = 0;
        bad         = 0;
        rst_ni      = 1'b0;
        dev_a_ready = 1'b1;
        dev_err     = 1'b0;
        for (int h = 0; h < NumHosts; h++) h_dready[h] = 1'b1;

        #3;
        checkOutput("rst_idle",     32'(idle_o),            32'd1);
        checkOutput("rst_gnt",      32'(gnt_o),             32'd0);
        checkOutput("rst_a_valid",  32'(tl_d_o.a_valid),    32'd0);
        checkOutput("rst_d_ready",  32'(tl_d_o.d_ready),    32'd0);
        checkOutput("rst_h0_aready", 32'(tl_h_o[0].a_ready), 32'd0);
        checkOutput("rst_h1_dvalid", 32'(tl_h_o[1].d_valid), 32'd0);
        #19;
        rst_ni = 1'b1;

        // Single Get from host0, accepted in the cycle it is presented.
        tick();
        applyStimulus(0, Get, 32'h10, 32'h0, 4'hF, 8'h11, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0010);
        @(negedge clk_i);
        checkOutput("t1_a_valid",   32'(tl_d_o.a_valid),    32'd1);
        checkOutput("t1_a_addr",    tl_d_o.a_address,       32'h10);
        checkOutput("t1_h0_aready", 32'(tl_h_o[0].a_ready), 32'd1);
        checkOutput("t1_h1_aready", 32'(tl_h_o[1].a_ready), 32'd0);
        checkOutput("t1_idle_pre",  32'(idle_o),            32'd1);
        @(negedge clk_i);
        checkOutput("t1_gnt",       32'(gnt_o),             32'b01);
        checkOutput("t1_idle",      32'(idle_o),            32'd0);
        checkOutput("t1_h0_dvalid", 32'(tl_h_o[0].d_valid), 32'd1);
        checkOutput("t1_h1_dvalid", 32'(tl_h_o[1].d_valid), 32'd0);
        @(negedge clk_i);
        checkOutput("t1_idle_post", 32'(idle_o),            32'd1);
        wait_drain(50);

        // PutFullData from host1 with device error; pointer returns to host0 afterwards.
        tick();
        dev_err = 1'b1;
        applyStimulus(1, PutFullData, 32'h24, 32'hDEAD_BEEF, 4'hF, 8'h66, 1'b1, AccessAck, 1'b1, 32'h0);
        @(negedge clk_i);
        checkOutput("t6_a_data",   tl_d_o.a_data,          32'hDEAD_BEEF);
        checkOutput("t6_a_mask",   32'(tl_d_o.a_mask),     32'hF);
        checkOutput("t6_a_opcode", 32'(tl_d_o.a_opcode),   32'(PutFullData));
        checkOutput("t6_a_source", 32'(tl_d_o.a_source),   32'h66);
        wait_drain(50);
        tick();
        dev_err = 1'b0;

        // Both hosts contend for six transactions; grants alternate starting at host0.
        tick();
        applyStimulus(0, Get, 32'h20, 32'h0, 4'hF, 8'h20, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0020);
        applyStimulus(1, Get, 32'h30, 32'h0, 4'hF, 8'h30, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0030);
        applyStimulus(0, Get, 32'h21, 32'h0, 4'hF, 8'h21, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0021);
        applyStimulus(1, Get, 32'h31, 32'h0, 4'hF, 8'h31, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0031);
        applyStimulus(0, Get, 32'h22, 32'h0, 4'hF, 8'h22, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0022);
        applyStimulus(1, Get, 32'h32, 32'h0, 4'hF, 8'h32, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0032);
        wait_drain(100);

        // Device stalls a_ready for three cycles; host1 arrives but host0 keeps the port.
        tick();
        dev_a_ready = 1'b0;
        applyStimulus(0, Get, 32'h40, 32'h0, 4'hF, 8'h41, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0040);
        @(negedge clk_i);
        checkOutput("t3_h0_aready0", 32'(tl_h_o[0].a_ready), 32'd0);
        checkOutput("t3_a_valid",    32'(tl_d_o.a_valid),    32'd1);
        tick();
        applyStimulus(1, Get, 32'h50, 32'h0, 4'hF, 8'h51, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0050);
        @(negedge clk_i);
        checkOutput("t3_gnt_addr",   32'(gnt_o),             32'b01);
        checkOutput("t3_idle",       32'(idle_o),            32'd0);
        checkOutput("t3_a_source",   32'(tl_d_o.a_source),   32'h41);
        checkOutput("t3_h1_aready",  32'(tl_h_o[1].a_ready), 32'd0);
        @(negedge clk_i);
        checkOutput("t3_gnt_hold",   32'(gnt_o),             32'b01);
        tick();
        dev_a_ready = 1'b1;
        @(negedge clk_i);
        checkOutput("t3_h0_aready1", 32'(tl_h_o[0].a_ready), 32'd1);
        checkOutput("t3_h1_aready1", 32'(tl_h_o[1].a_ready), 32'd0);
        wait_drain(50);

        // Host0 stalls d_ready for four cycles; no regrant, then host1 wins the next round.
        tick();
        h_dready[0] = 1'b0;
        applyStimulus(0, Get, 32'h60, 32'h0, 4'hF, 8'h61, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0060);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("t4_d_ready",    32'(tl_d_o.d_ready),    32'd0);
        checkOutput("t4_h0_dvalid",  32'(tl_h_o[0].d_valid), 32'd1);
        tick();
        applyStimulus(1, Get, 32'h70, 32'h0, 4'hF, 8'h71, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0070);
        applyStimulus(0, Get, 32'h62, 32'h0, 4'hF, 8'h62, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0062);
        @(negedge clk_i);
        checkOutput("t4_gnt",        32'(gnt_o),             32'b01);
        checkOutput("t4_a_valid",    32'(tl_d_o.a_valid),    32'd0);
        checkOutput("t4_h1_aready",  32'(tl_h_o[1].a_ready), 32'd0);
        checkOutput("t4_d_source",   32'(tl_h_o[0].d_source), 32'h61);
        @(negedge clk_i);
        @(negedge clk_i);
        tick();
        h_dready[0] = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("t4_idle",       32'(idle_o),            32'd1);
        checkOutput("t4_rr_h1",      32'(tl_h_o[1].a_ready), 32'd1);
        checkOutput("t4_rr_h0",      32'(tl_h_o[0].a_ready), 32'd0);
        checkOutput("t4_rr_source",  32'(tl_d_o.a_source),   32'h71);
        wait_drain(50);

        // Asynchronous reset while a response is pending; that response is dropped.
        tick();
        h_dready[0] = 1'b0;
        applyStimulus(0, Get, 32'h80, 32'h0, 4'hF, 8'h81, 1'b0, AccessAckData, 1'b0, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("t5_pre_dvalid", 32'(tl_h_o[0].d_valid), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("t5_idle",       32'(idle_o),            32'd1);
        checkOutput("t5_gnt",        32'(gnt_o),             32'd0);
        checkOutput("t5_h0_dvalid",  32'(tl_h_o[0].d_valid), 32'd0);
        checkOutput("t5_a_valid",    32'(tl_d_o.a_valid),    32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        tick();
        h_dready[0] = 1'b1;
        applyStimulus(1, Get, 32'h90, 32'h0, 4'hF, 8'h91, 1'b1, AccessAckData, 1'b0, 32'hA5A5_0090);
        @(negedge clk_i);
        checkOutput("t5_h1_aready",  32'(tl_h_o[1].a_ready), 32'd1);
        checkOutput("t5_a_source",   32'(tl_d_o.a_source),   32'h91);
        wait_drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
